instr_exec_unit: RTL and testbench
==================================

INSTR_EXEC_UNIT -- requirements
Module: instr_exec_unit

Interface
REQ-001 SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state changes on rising edge
  reset_n  in  1  asynchronous, active-low reset
  start  in  1  begin a run; sampled only in IDLE
  num_instr  in  6  instructions per run; 0..32, values >32 clamp to 32
  read_pointer  out  address_t (5)  address presented to the instruction register
  instruction_word  in  instruction_t  combinational read data for read_pointer, same cycle
  result  out  result_t (64 signed)  computed result
  result_opcode  out  opcode_t  opcode that produced result
  result_addr  out  address_t  register address that produced result
  div_zero  out  1  qualifies result: DIV/MOD with operand_b==0
  result_valid  out  1  result fields valid
  result_ready  in  1  consumer accepts when result_valid&&result_ready
  busy  out  1  high outside IDLE
  done  out  1  one-cycle pulse on run completion

Function
REQ-002 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-003 IDLE: start=1 -> latch clamped num_instr, read_pointer=0, go RUN; num_instr==0 -> go DONE directly, no results produced.
REQ-004 RUN: SHALL capture instruction_word into output register when output register empty or being accepted this cycle ("issue"); read_pointer increments on each issue.
REQ-005 Latency SHALL be 1 cycle: issue in cycle N -> result_valid in cycle N+1.
REQ-006 While result_valid&&!result_ready, output register, read_pointer and FSM SHALL hold unchanged.
REQ-007 Issue of last instruction (count reached) -> DRAIN; DRAIN -> DONE on final acceptance.
REQ-008 DONE: done=1 for exactly one cycle, then IDLE; start ignored in RUN/DRAIN/DONE.
REQ-009 Opcode ZERO->0, PASSA->op_a, PASSB->op_b, ADD->a+b, SUB->a-b, MULT->a*b full 64-bit, DIV->a/b truncated toward zero, MOD->a%b sign of dividend; 32-bit operands sign-extended before operation.
REQ-010 DIV/MOD with op_b==0 SHALL give result 0, div_zero=1; div_zero=0 otherwise.
REQ-011 read_pointer wrap at 32 instructions SHALL not occur within a run; 32-instruction run ends at address 31.
REQ-012 Back-to-back runs: new start accepted only in the cycle after done (IDLE).

Reset
REQ-013 reset_n low, at any time including mid-run, SHALL immediately force IDLE, read_pointer=0, result=0, result_opcode=ZERO, result_addr=0, div_zero=0, result_valid=0, busy=0, done=0; pending result discarded.
REQ-014 First start SHALL be sampled no earlier than the first rising edge after reset_n deasserts.

Configuration
REQ-015 Macro INSTR_EXEC_DIV_EN defined: DIV/MOD per REQ-009/010.
REQ-016 Macro INSTR_EXEC_DIV_EN undefined: no divider logic; DIV/MOD give result 0, div_zero=0; all other opcodes unchanged.

Structure
REQ-017 opcode_t, operand_t, address_t, instruction_t SHALL come from instr_register_pkg; result_t (signed 64) and MAX_INSTR=32 SHALL be added there.
REQ-018 Opcode arithmetic SHALL be a combinational sub-module instr_alu (instruction_t in, result_t plus div_zero out); FSM and output register stay in instr_exec_unit.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
  ADD a=5,b=-3 at addr 0, num_instr=1, ready=1 -> result=2 one cycle after issue, result_addr=0, done pulse, busy falls.
  MULT a=0x7FFFFFFF,b=2 -> result=0x00000000FFFFFFFE; SUB a=-10,b=7 -> -17.
  DIV a=-7,b=2 -> -3; MOD a=-7,b=2 -> -1; DIV a=9,b=0 -> result 0, div_zero=1 (macro off: 0, div_zero 0).
  num_instr=32, result_ready low 3 cycles mid-run -> result/read_pointer held, 32 results addr 0..31 in order, no loss or duplicate.
  num_instr=0 -> done pulse next cycle, result_valid never asserted; num_instr=40 -> exactly 32 results.
  reset_n low during RUN at read_pointer=7 -> all outputs at reset values; later start replays from addr 0.

Source files
------------

// File: rtl/instr_register_pkg.sv
// ============================================================================
//  Module      : instr_register_pkg
//  Description : Shared types for the instruction register and the execution
//                unit: opcodes, operands, addresses, instruction word, the
//                64-bit signed result type and the executor FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    localparam int MAX_INSTR = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } exec_state_t;

    // Requested run length saturates at the size of the register file.
    function automatic logic [5:0] clamp_count(input logic [5:0] n);
        if (n > 6'(MAX_INSTR)) begin
            return 6'(MAX_INSTR);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_alu.sv
// ============================================================================
//  Module      : instr_alu
//  Description : Combinational opcode evaluation. Operands are sign-extended
//                to 64 bits before any arithmetic. Divider logic is present
//                only when INSTR_EXEC_DIV_EN is defined; otherwise DIV/MOD
//                return zero with div_zero clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      result,
    output logic         div_zero
);

    result_t a_ext;
    result_t b_ext;

    assign a_ext = {{32{instr.op_a[31]}}, instr.op_a};
    assign b_ext = {{32{instr.op_b[31]}}, instr.op_b};

    // Select the arithmetic result for the current opcode.
    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (instr.opc)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
`ifdef INSTR_EXEC_DIV_EN
            // A zero divisor yields zero and is flagged instead of computed.
            DIV: begin
                if (instr.op_b == '0) div_zero = 1'b1;
                else                  result   = a_ext / b_ext;
            end
            MOD: begin
                if (instr.op_b == '0) div_zero = 1'b1;
                else                  result   = a_ext % b_ext;
            end
`else
            DIV:   result = '0;
            MOD:   result = '0;
`endif
            default: result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_exec_unit.sv
// ============================================================================
//  Module      : instr_exec_unit
//  Description : Walks the instruction register from address 0, evaluates each
//                instruction through instr_alu and holds one result in an
//                output register under a valid/ready handshake.
//                Optional divider: define INSTR_EXEC_DIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_exec_unit
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [5:0]   num_instr,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output result_t      result,
    output opcode_t      result_opcode,
    output address_t     result_addr,
    output logic         div_zero,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         busy,
    output logic         done
);

    exec_state_t state_q, state_d;
    logic [5:0]  remaining_q, remaining_d;
    address_t    rp_q, rp_d;
    result_t     result_q, result_d;
    opcode_t     opc_q, opc_d;
    address_t    addr_q, addr_d;
    logic        dz_q, dz_d;
    logic        valid_q, valid_d;

    result_t     alu_result;
    logic        alu_div_zero;
    logic        issue;
    logic        accept;

    instr_alu u_alu (
        .instr    (instruction_word),
        .result   (alu_result),
        .div_zero (alu_div_zero)
    );

    // An issue may refill the output register in the same cycle it drains.
    assign accept = valid_q && result_ready;
    assign issue  = (state_q == S_RUN) && (!valid_q || result_ready);

    // State and datapath registers; reset discards any pending result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            rp_q        <= '0;
            result_q    <= '0;
            opc_q       <= ZERO;
            addr_q      <= '0;
            dz_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rp_q        <= rp_d;
            result_q    <= result_d;
            opc_q       <= opc_d;
            addr_q      <= addr_d;
            dz_q        <= dz_d;
            valid_q     <= valid_d;
        end
    end

    // Next state, instruction sequencing and output-register loading.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rp_d        = rp_q;
        result_d    = result_q;
        opc_d       = opc_q;
        addr_d      = addr_q;
        dz_d        = dz_q;
        valid_d     = valid_q;

        if (accept) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = clamp_count(num_instr);
                    rp_d        = '0;
                    state_d     = (clamp_count(num_instr) == 6'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    result_d    = alu_result;
                    opc_d       = instruction_word.opc;
                    addr_d      = rp_q;
                    dz_d        = alu_div_zero;
                    valid_d     = 1'b1;
                    remaining_d = remaining_q - 6'd1;
                    // The pointer stops on the last address rather than wrapping.
                    if (remaining_q == 6'd1) state_d = S_DRAIN;
                    else                     rp_d    = rp_q + 5'd1;
                end
            end
            S_DRAIN: begin
                if (accept) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign read_pointer  = rp_q;
    assign result        = result_q;
    assign result_opcode = opc_q;
    assign result_addr   = addr_q;
    assign div_zero      = dz_q;
    assign result_valid  = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_exec_unit.sv
// ============================================================================
//  Module      : tb_instr_exec_unit
//  Description : Self-checking bench for instr_exec_unit. A vector table of
//                opcode/operand/expected records is loaded into a model
//                instruction register and run as one program; hand-written
//                sequences cover single-instruction timing, back-pressure,
//                zero/oversize runs and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_exec_unit;
    import instr_register_pkg::*;

`ifdef INSTR_EXEC_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   num_instr = '0;
    address_t     read_pointer;
    instruction_t instruction_word;
    result_t      result;
    opcode_t      result_opcode;
    address_t     result_addr;
    logic         div_zero;
    logic         result_valid;
    logic         result_ready = 1'b1;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    longint       exp_res [32];
    bit           exp_dz  [32];
    opcode_t      exp_opc [32];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_exec_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .num_instr        (num_instr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result           (result),
        .result_opcode    (result_opcode),
        .result_addr      (result_addr),
        .div_zero         (div_zero),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .done             (done)
    );

    typedef struct {
        opcode_t opc;
        int      a;
        int      b;
        longint  exp_r;
        bit      exp_dz;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rp"},     longint'(read_pointer), 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_opc"},    longint'(result_opcode), longint'(ZERO));
        chk({tag, "_addr"},   longint'(result_addr), 0);
        chk({tag, "_dz"},     longint'(div_zero), 0);
        chk({tag, "_valid"},  longint'(result_valid), 0);
        chk({tag, "_busy"},   longint'(busy), 0);
        chk({tag, "_done"},   longint'(done), 0);
    endtask

    // Program of ADD i,k at every address.
    task automatic load_add_program(input int k);
        for (int i = 0; i < 32; i++) begin
            mem[i]     = '{opc: ADD, op_a: i, op_b: k};
            exp_res[i] = longint'(i + k);
            exp_dz[i]  = 1'b0;
            exp_opc[i] = ADD;
        end
    endtask

    // Start a run and consume results in order; stall_at >= 0 holds ready low
    // for three cycles while that result index is pending.
    task automatic run_prog(input int num, input int n_exp, input int stall_at);
        int      acc = 0;
        int      stall = 0;
        int      cyc = 0;
        bit      seen_done = 1'b0;
        bit      held = 1'b0;
        bit      ready_v;
        result_t snap_res = '0;
        address_t snap_rp = '0;
        @(negedge clk);
        start        = 1'b1;
        num_instr    = num[5:0];
        result_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!seen_done && cyc < 200) begin
            cyc++;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (held) begin
                    chk("hold_result", result, snap_res);
                    chk("hold_rp", longint'(read_pointer), longint'(snap_rp));
                end
                ready_v = !(acc == stall_at && stall < 3);
                if (!ready_v) stall++;
                result_ready = ready_v;
                if (result_valid && ready_v) begin
                    if (acc < 32) begin
                        chk("res_value", result, exp_res[acc]);
                        chk("res_addr", longint'(result_addr), longint'(acc));
                        chk("res_opc", longint'(result_opcode), longint'(exp_opc[acc]));
                        chk("res_dz", longint'(div_zero), longint'(exp_dz[acc]));
                    end
                    acc++;
                end
                held = result_valid && !ready_v;
                snap_res = result;
                snap_rp  = read_pointer;
                @(negedge clk);
            end
        end
        chk("run_done_seen", longint'(seen_done), 1);
        chk("run_n_results", longint'(acc), longint'(n_exp));
        if (stall_at >= 0) chk("run_stall_cycles", longint'(stall), 3);
        result_ready = 1'b1;
        @(negedge clk);
        chk("run_done_pulse_end", longint'(done), 0);
        chk("run_busy_end", longint'(busy), 0);
        chk("run_valid_end", longint'(result_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '{opc: ZERO, op_a: 0, op_b: 0};

        // Vector table: opcode, a, b, expected result, expected div_zero.
        vt[0]  = '{ADD,   5,              -3, 2, 1'b0};
        vt[1]  = '{MULT,  32'h7FFF_FFFF,  2,  64'h0000_0000_FFFF_FFFE, 1'b0};
        vt[2]  = '{SUB,   -10,            7,  -17, 1'b0};
        vt[3]  = '{DIV,   -7,             2,  DIV_ON ? -3 : 0, 1'b0};
        vt[4]  = '{MOD,   -7,             2,  DIV_ON ? -1 : 0, 1'b0};
        vt[5]  = '{DIV,   9,              0,  0, DIV_ON};
        vt[6]  = '{ZERO,  123,            456, 0, 1'b0};
        vt[7]  = '{PASSA, -42,            9,  -42, 1'b0};
        vt[8]  = '{PASSB, 11,             -8, -8, 1'b0};
        vt[9]  = '{MULT,  -3,             4,  -12, 1'b0};
        vt[10] = '{MOD,   7,              -2, DIV_ON ? 1 : 0, 1'b0};
        vt[11] = '{DIV,   int'(32'h8000_0000), -1, DIV_ON ? 64'sh8000_0000 : 0, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;

        // Single ADD: result one cycle after issue, done pulse, busy falls.
        mem[0] = '{opc: ADD, op_a: 5, op_b: -3};
        @(negedge clk);
        start = 1'b1; num_instr = 6'd1; result_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("add_busy_run", longint'(busy), 1);
        chk("add_valid_issue_cycle", longint'(result_valid), 0);
        chk("add_rp_issue", longint'(read_pointer), 0);
        @(posedge clk); #1;
        chk("add_valid", longint'(result_valid), 1);
        chk("add_result", result, 2);
        chk("add_addr", longint'(result_addr), 0);
        chk("add_opc", longint'(result_opcode), longint'(ADD));
        chk("add_done_early", longint'(done), 0);
        @(posedge clk); #1;
        chk("add_done", longint'(done), 1);
        chk("add_valid_after", longint'(result_valid), 0);
        @(posedge clk); #1;
        chk("add_done_once", longint'(done), 0);
        chk("add_busy_idle", longint'(busy), 0);

        // Table program: all vectors in one run.
        for (int i = 0; i < 12; i++) begin
            mem[i]     = '{opc: vt[i].opc, op_a: vt[i].a, op_b: vt[i].b};
            exp_res[i] = vt[i].exp_r;
            exp_dz[i]  = vt[i].exp_dz;
            exp_opc[i] = vt[i].opc;
        end
        run_prog(12, 12, -1);

        // Full 32-instruction run with back-pressure mid-run.
        load_add_program(100);
        run_prog(32, 32, 10);

        // Oversize request clamps to 32.
        load_add_program(500);
        run_prog(40, 32, -1);

        // Zero-length run: done the next cycle, never valid.
        @(negedge clk);
        start = 1'b1; num_instr = 6'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done", longint'(done), 1);
        chk("zero_valid", longint'(result_valid), 0);
        @(posedge clk); #1;
        chk("zero_done_once", longint'(done), 0);
        chk("zero_busy", longint'(busy), 0);
        chk("zero_valid2", longint'(result_valid), 0);
        run_prog(0, 0, -1);

        // Reset mid-run at read_pointer 7, then replay from address 0.
        load_add_program(1000);
        @(negedge clk);
        start = 1'b1; num_instr = 6'd32; result_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int cyc = 0;
            while (read_pointer != 5'd7 && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            chk("rst_reach_rp7", longint'(read_pointer), 7);
        end
        chk("rst_busy_before", longint'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrun");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_prog(3, 3, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
